// File: rtl/mult_sequencer.sv
// Control sequencer for a shift-and-add multiplier: clear, load, WORD_LENGTH accumulate steps, done.
// Optional early exit on an all-zero multiplier is compiled in by defining MULT_SEQUENCER_EARLY_EXIT_EN.
module mult_sequencer #(
    parameter int WORD_LENGTH = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               abort,
    input  logic                               mplier_zero,
    output logic                               sync_reset,
    output logic                               load,
    output logic                               shift,
    output logic                               acc_enable,
    output logic                               ready,
    output logic                               done,
    output logic [$clog2(WORD_LENGTH+1)-1:0]   iter
);

    localparam int IW = $clog2(WORD_LENGTH + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LOAD  = 3'd2,
        ACCUM = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] iter_q, iter_d;
    logic          early_exit;

`ifdef MULT_SEQUENCER_EARLY_EXIT_EN
    assign early_exit = mplier_zero;
`else
    logic unused_mplier_zero;
    assign unused_mplier_zero = mplier_zero;
    assign early_exit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
        end
    end

    // The last ACCUM cycle is the one that sees iter = WORD_LENGTH-1, so DONE shows the full count.
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) state_d = CLEAR;
            end
            CLEAR: begin
                state_d = abort ? IDLE : LOAD;
            end
            LOAD: begin
                iter_d  = '0;
                state_d = abort ? IDLE : ACCUM;
            end
            ACCUM: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (early_exit) begin
                    state_d = DONE;
                end else begin
                    iter_d = iter_q + IW'(1);
                    if (iter_q == IW'(WORD_LENGTH - 1)) state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        sync_reset = 1'b0;
        load       = 1'b0;
        shift      = 1'b0;
        acc_enable = 1'b0;
        ready      = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE:  ready      = 1'b1;
            CLEAR: sync_reset = 1'b1;
            LOAD:  load       = 1'b1;
            ACCUM: begin
                shift      = !early_exit;
                acc_enable = !early_exit;
            end
            DONE:  done       = 1'b1;
            default: ready    = 1'b0;
        endcase
    end

    assign iter = iter_q;

endmodule
